// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 single-path delay-feedback FFT stage.
// Drives delay-line shift, butterfly select, twiddle address and output framing.
module fft_sdf_stage_ctrl #(
    parameter int unsigned N_HALF = 8,
    parameter int unsigned AW     = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          din_valid,
    input  logic          din_sop,
    output logic          din_ready,
    input  logic          flush,
    output logic          sr_en,
    output logic          bf_sel,
    output logic [AW-1:0] tw_addr,
    output logic          dout_valid,
    output logic          dout_sop,
    output logic          dout_eop,
    output logic          sop_err
);

    typedef enum logic [2:0] {StIdle, StFill, StBfly, StWait, StDrain} state_e;

    localparam logic [AW-1:0] CntLast = AW'(N_HALF - 1);
    localparam logic [AW-1:0] CntOne  = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          sr_en_d, bf_sel_d, dout_valid_d, dout_sop_d, dout_eop_d, sop_err_d;
    logic [AW-1:0] tw_addr_d;
    logic          accept;
    logic          cnt_last;

    assign din_ready = (state_q != StDrain);
    assign accept    = din_valid & din_ready;
    assign cnt_last  = (cnt_q == CntLast);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        sr_en_d      = 1'b0;
        bf_sel_d     = 1'b0;
        tw_addr_d    = tw_addr;
        dout_valid_d = 1'b0;
        dout_sop_d   = 1'b0;
        dout_eop_d   = 1'b0;
        sop_err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (din_sop) begin
                        sr_en_d = 1'b1;
                        cnt_d   = CntOne;
                        state_d = StFill;
                    end else begin
                        sop_err_d = 1'b1;
                    end
                end
            end
            StFill, StBfly: begin
                if (accept) begin
                    sr_en_d = 1'b1;
                    if (din_sop) begin
                        // Restart: the sample opens a new frame, any pending drain keeps flowing.
                        sop_err_d    = 1'b1;
                        dout_valid_d = pend_q;
                        cnt_d        = CntOne;
                        state_d      = StFill;
                    end else if (state_q == StFill) begin
                        dout_valid_d = pend_q;
                        dout_eop_d   = pend_q & cnt_last;
                        cnt_d        = cnt_q + 1'b1;
                        if (cnt_last) begin
                            cnt_d   = '0;
                            pend_d  = 1'b0;
                            state_d = StBfly;
                        end
                    end else begin
                        bf_sel_d     = 1'b1;
                        tw_addr_d    = cnt_q;
                        dout_valid_d = 1'b1;
                        dout_sop_d   = (cnt_q == '0);
                        cnt_d        = cnt_q + 1'b1;
                        if (cnt_last) begin
                            cnt_d   = '0;
                            pend_d  = 1'b1;
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                if (accept) begin
                    if (din_sop) begin
                        sr_en_d      = 1'b1;
                        dout_valid_d = pend_q;
                        cnt_d        = CntOne;
                        state_d      = StFill;
                    end else begin
                        sop_err_d = 1'b1;
                    end
                end else if (flush) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                sr_en_d      = 1'b1;
                dout_valid_d = 1'b1;
                dout_eop_d   = cnt_last;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_last) begin
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            sr_en      <= 1'b0;
            bf_sel     <= 1'b0;
            tw_addr    <= '0;
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
            sop_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            sr_en      <= sr_en_d;
            bf_sel     <= bf_sel_d;
            tw_addr    <= tw_addr_d;
            dout_valid <= dout_valid_d;
            dout_sop   <= dout_sop_d;
            dout_eop   <= dout_eop_d;
            sop_err    <= sop_err_d;
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Scoreboard bench for fft_sdf_stage_ctrl: a frame-position reference model predicts
// each output event, a negedge monitor pops and compares what the DUT presents.
module tb_fft_sdf_stage_ctrl;

    localparam int NH = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       din_valid = 1'b0;
    logic       din_sop = 1'b0;
    logic       flush = 1'b0;
    logic       din_ready;
    logic       sr_en, bf_sel, dout_valid, dout_sop, dout_eop, sop_err;
    logic [2:0] tw_addr;

    fft_sdf_stage_ctrl #(.N_HALF(NH), .AW(3)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_sop    (din_sop),
        .din_ready  (din_ready),
        .flush      (flush),
        .sr_en      (sr_en),
        .bf_sel     (bf_sel),
        .tw_addr    (tw_addr),
        .dout_valid (dout_valid),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .sop_err    (sop_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sr;
        logic       bf;
        logic [2:0] tw;
        logic       dv;
        logic       ds;
        logic       de;
        logic       err;
    } outv_t;

    typedef struct {
        int    cyc;
        outv_t v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: position within the frame (samples taken so far, 0..2*NH),
    // whether the previous frame's second half is still owed, and drain ticks left.
    bit         m_pend = 1'b0;
    int         m_pos = 0;
    int         m_drain = 0;
    logic [2:0] m_tw = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        outv_t act;
        exp_t  e;
        act = {sr_en, bf_sel, tw_addr, dout_valid, dout_sop, dout_eop, sop_err};
        if (!rstn) begin
            checks++;
            if (act !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d got %b want 0", cyc, act);
            end
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event cyc %0d got none want %b", sb[0].cyc, sb[0].v);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL event cyc %0d got %b want %b (sr bf tw dv ds de err)",
                             cyc, act, e.v);
                end
            end else if (act.sr | act.bf | act.dv | act.ds | act.de | act.err) begin
                checks++;
                errors++;
                $display("FAIL spurious_event cyc %0d got %b want none", cyc, act);
            end
        end
    end

    task automatic step(input logic v, input logic s, input logic f);
        exp_t e;
        bit   ev;
        int   k;
        @(posedge clk);
        #1;
        din_valid = v;
        din_sop   = s;
        flush     = f;
        checks++;
        if (din_ready !== (m_drain == 0)) begin
            errors++;
            $display("FAIL din_ready cyc %0d got %b want %b", cyc, din_ready, m_drain == 0);
        end
        e.cyc = cyc + 1;
        e.v   = '0;
        ev    = 1'b0;
        if (m_drain > 0) begin
            ev     = 1'b1;
            e.v.sr = 1'b1;
            e.v.dv = 1'b1;
            e.v.de = (m_drain == 1);
            m_drain--;
            if (m_drain == 0) begin
                m_pend = 1'b0;
                m_pos  = 0;
            end
        end else if (v) begin
            ev = 1'b1;
            if (s) begin
                e.v.err = (m_pos >= 1 && m_pos <= 2 * NH - 1);
                e.v.sr  = 1'b1;
                e.v.dv  = m_pend;
                m_pos   = 1;
            end else if (m_pos == 0 || m_pos == 2 * NH) begin
                e.v.err = 1'b1;
            end else begin
                k      = m_pos + 1;
                e.v.sr = 1'b1;
                if (k <= NH) begin
                    e.v.dv = m_pend;
                    e.v.de = m_pend && (k == NH);
                    if (k == NH) m_pend = 1'b0;
                end else begin
                    e.v.bf = 1'b1;
                    m_tw   = 3'(k - NH - 1);
                    e.v.dv = 1'b1;
                    e.v.ds = (k == NH + 1);
                    if (k == 2 * NH) m_pend = 1'b1;
                end
                m_pos = k;
            end
        end else if (f && m_pos == 2 * NH) begin
            m_drain = NH;
        end
        e.v.tw = m_tw;
        if (ev) sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            if (toggle && i > 0) step(1'b0, 1'b0, 1'b0);
            step(1'b1, i == 0, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        flush     = 1'b0;
        rstn      = 1'b0;
        m_pend    = 1'b0;
        m_pos     = 0;
        m_drain   = 0;
        m_tw      = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        bit v, s, f;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Single frame, then flush-driven drain.
        frame(16, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(10);

        // Back-to-back frames: the second FILL carries the first frame's tail.
        frame(16, 1'b0);
        frame(16, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(10);

        // Alternating valid gaps.
        frame(16, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(10);

        // Stray sop on the 4th butterfly sample restarts the frame.
        frame(11, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (15) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(10);

        // Reset in the middle of the butterfly phase.
        frame(13, 1'b0);
        do_reset();
        frame(16, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(10);

        // Stray sample and flushes where they must be ignored.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        frame(4, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (12) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (15) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(10);

        // Randomized traffic.
        repeat (500) begin
            v = ($urandom_range(0, 99) < 70);
            if (m_pos == 0 || m_pos == 2 * NH) s = v && ($urandom_range(0, 9) < 8);
            else s = v && ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 5) == 0);
            step(v, s, f);
        end
        idle(12);

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
